// File: rtl/openhw_flop_pkg.sv
// openhw_flop_pkg: shared constants and sizing helpers for the openhw_flopchain pipeline primitive
package openhw_flop_pkg;
  localparam int DEPTH_MAX = 16;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/openhw_flopchain_stage.sv
// openhw_flopchain_stage: one valid bit plus WIDTH data register; data reset only with OPENHW_FLOPCHAIN_DATA_RESET_EN
module openhw_flopchain_stage
  import openhw_flop_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (reset || clear) valid <= 1'b0;
    else if (en) valid <= in_valid;
  end
`ifdef OPENHW_FLOPCHAIN_DATA_RESET_EN
  always_ff @(posedge clk) begin
    if (reset || clear) data <= '0;
    else if (en && in_valid) data <= in_data;
  end
`else
  // enable-only data flop: contents are meaningless while valid is low
  always_ff @(posedge clk) begin
    if (en && in_valid) data <= in_data;
  end
`endif
endmodule

// File: rtl/openhw_flopchain.sv
// openhw_flopchain: elastic DEPTH-stage pipeline register chain with stall, flush and bubble collapse
// optional data reset enabled by defining OPENHW_FLOPCHAIN_DATA_RESET_EN
module openhw_flopchain
  import openhw_flop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [occ_width(DEPTH)-1:0]    occupancy
);
  localparam int OW = occ_width(DEPTH);
  logic [DEPTH-1:0] v, r, vin;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("openhw_flopchain: DEPTH must be in 1..16");
  end
  // a stage may advance whenever it or anything downstream is empty
  always_comb begin
    r[DEPTH-1] = ~v[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) r[k] = ~v[k] | r[k+1];
  end
  assign in_ready  = r[0] & ~reset & ~clear;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign vin[i] = in_valid & in_ready;
      assign din[i] = in_data;
    end else begin : g_body
      assign vin[i] = v[i-1];
      assign din[i] = d[i-1];
    end
    openhw_flopchain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .en       (r[i]),
      .in_valid (vin[i]),
      .in_data  (din[i]),
      .valid    (v[i]),
      .data     (d[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset || clear) occupancy <= '0;
    else occupancy <= occupancy + OW'(in_valid & in_ready) - OW'(out_valid & out_ready);
  end
endmodule

// File: tb/tb_openhw_flopchain.sv
// tb_openhw_flopchain: table-driven checks of a DEPTH=3 chain plus a DEPTH=1 elastic register sequence
module tb_openhw_flopchain;
  logic clk = 1'b0;
  logic reset, clear, in_valid, out_ready, in_ready, out_valid;
  logic [7:0] in_data, out_data;
  logic [1:0] occ;
  logic s_clear, s_iv, s_ordy, s_ir, s_ov;
  logic [7:0] s_id, s_od;
  logic [0:0] s_occ;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  openhw_flopchain #(.WIDTH(8), .DEPTH(3)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occ)
  );

  openhw_flopchain #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .clear(s_clear), .in_valid(s_iv), .in_ready(s_ir),
    .in_data(s_id), .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_od),
    .occupancy(s_occ)
  );

  typedef struct {
    logic rst, clr, iv;
    logic [7:0] id;
    logic ordy;
    logic ir, ov;
    logic [7:0] od;
    logic [1:0] occ;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic clr, logic iv, logic [7:0] id, logic ordy,
                              logic ir, logic ov, logic [7:0] od, logic [1:0] oc);
    vec_t x;
    x.rst = rst; x.clr = clr; x.iv = iv; x.id = id; x.ordy = ordy;
    x.ir = ir; x.ov = ov; x.od = od; x.occ = oc;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic s_step(input int idx, input logic iv, input logic [7:0] id, input logic ordy,
                        input logic ir, input logic ov, input logic [7:0] od, input logic oc);
    @(negedge clk);
    s_iv = iv; s_id = id; s_ordy = ordy;
    #2;
    chk("d1_in_ready", idx, {7'd0, s_ir}, {7'd0, ir});
    chk("d1_out_valid", idx, {7'd0, s_ov}, {7'd0, ov});
    chk("d1_occupancy", idx, {7'd0, s_occ}, {7'd0, oc});
    if (ov) chk("d1_out_data", idx, s_od, od);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_clear = 1'b0; s_iv = 1'b0; s_id = '0; s_ordy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset_in_ready", -1, {7'd0, in_ready}, 8'd0);
    chk("reset_out_valid", -1, {7'd0, out_valid}, 8'd0);
    chk("reset_occupancy", -1, {6'd0, occ}, 8'd0);
    // streaming 0x01..0x0A with out_ready high
    tv.push_back(mk(0,0,1,8'h01,1, 1,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'h02,1, 1,0,8'h00,1));
    tv.push_back(mk(0,0,1,8'h03,1, 1,0,8'h00,2));
    for (int k = 3; k <= 9; k++) tv.push_back(mk(0,0,1,8'(k+1),1, 1,1,8'(k-2),3));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h08,3));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h09,2));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h0A,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0));
    // back-pressure
    tv.push_back(mk(0,0,1,8'hA1,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'hA2,0, 1,0,8'h00,1));
    tv.push_back(mk(0,0,1,8'hA3,0, 1,0,8'h00,2));
    tv.push_back(mk(0,0,1,8'hA4,0, 0,1,8'hA1,3));
    tv.push_back(mk(0,0,1,8'hA4,1, 1,1,8'hA1,3));
    tv.push_back(mk(0,0,0,8'h00,0, 0,1,8'hA2,3));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'hA2,3));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'hA3,2));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'hA4,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0));
    // bubble collapse
    tv.push_back(mk(0,0,1,8'h11,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,1));
    tv.push_back(mk(0,0,1,8'h22,0, 1,1,8'h11,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,1,8'h11,2));
    tv.push_back(mk(0,0,0,8'h00,0, 1,1,8'h11,2));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h11,2));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h22,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,0));
    // single-cycle clear with a beat offered
    tv.push_back(mk(0,0,1,8'h31,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'h32,0, 1,0,8'h00,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,2));
    tv.push_back(mk(0,1,1,8'h55,0, 0,1,8'h31,2));
    for (int k = 0; k < 4; k++) tv.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0));
    // clear held for two cycles
    tv.push_back(mk(0,0,1,8'h61,0, 1,0,8'h00,0));
    tv.push_back(mk(0,1,1,8'h62,0, 0,0,8'h00,1));
    tv.push_back(mk(0,1,1,8'h63,0, 0,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'h64,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h64,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0));
    // reset while full
    tv.push_back(mk(0,0,1,8'h71,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'h72,0, 1,0,8'h00,1));
    tv.push_back(mk(0,0,1,8'h73,0, 1,0,8'h00,2));
    tv.push_back(mk(1,0,1,8'h74,1, 0,1,8'h71,3));
    tv.push_back(mk(1,0,1,8'h75,1, 0,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'h76,1, 1,0,8'h00,0));
    tv.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h76,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0));
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      reset = tv[i].rst; clear = tv[i].clr; in_valid = tv[i].iv;
      in_data = tv[i].id; out_ready = tv[i].ordy;
      #2;
      chk("in_ready", i, {7'd0, in_ready}, {7'd0, tv[i].ir});
      chk("out_valid", i, {7'd0, out_valid}, {7'd0, tv[i].ov});
      chk("occupancy", i, {6'd0, occ}, {6'd0, tv[i].occ});
      if (tv[i].ov) chk("out_data", i, out_data, tv[i].od);
    end
`ifdef OPENHW_FLOPCHAIN_DATA_RESET_EN
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    #2;
    chk("cleared_out_data", -2, out_data, 8'h00);
`endif
    // DEPTH=1 single elastic register
    s_step(0, 1, 8'h81, 0, 1, 0, 8'h00, 0);
    s_step(1, 1, 8'h82, 0, 0, 1, 8'h81, 1);
    for (int k = 0; k < 5; k++) s_step(2 + k, 1, 8'(8'h82 + k), 1, 1, 1, 8'(8'h81 + k), 1);
    s_step(7, 0, 8'h00, 1, 1, 1, 8'h86, 1);
    s_step(8, 0, 8'h00, 1, 1, 0, 8'h00, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
